// File: rtl/password_lock_if.sv
// password_lock_if: code-entry strobe/code from the keypad and the
// access/alarm drive lines back to the actuator side.
interface password_lock_if #(
    parameter int WIDTH = 32
) ();
    logic             enter;
    logic [WIDTH-1:0] in;
    logic             access;
    logic             alarm;
    modport master (output enter, output in, input access, input alarm);
    modport slave (input enter, input in, output access, output alarm);
endinterface

// File: rtl/password_lock.sv
// password_lock: keypad door lock with timed access and latched alarm.
// Optional macro ALARM_AUTOCLEAR_EN returns ALARM to LOCKED after ALARM_CYCLES.
module password_lock #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] PASSWORD     = 32'h12345678,
    parameter int               MAX_FAILS    = 3,
    parameter int               OPEN_CYCLES  = 16,
    parameter int               ALARM_CYCLES = 64
) (
    input logic            clk,
    input logic            reset,
    password_lock_if.slave bus
);
    if (MAX_FAILS < 1 || MAX_FAILS > 15 || OPEN_CYCLES < 1 || ALARM_CYCLES < 1) begin : g_bad_params
        $error("password_lock: illegal parameter values");
    end
    typedef enum logic [1:0] {LOCKED, OPEN, ALARM} state_t;
    localparam int             TW        = $clog2(OPEN_CYCLES + 1);
    localparam logic [TW-1:0]  OPEN_LOAD = TW'(OPEN_CYCLES);
    localparam logic [3:0]     MAX_F     = 4'(MAX_FAILS);
    state_t        state_q;
    logic [3:0]    fail_q;
    logic [TW-1:0] timer_q;
    logic          access_q;
    logic          alarm_q;
    logic          match;
    logic [3:0]    fail_inc;
    logic          to_alarm;
`ifdef ALARM_AUTOCLEAR_EN
    localparam int             AW         = $clog2(ALARM_CYCLES + 1);
    localparam logic [AW-1:0]  ALARM_LOAD = AW'(ALARM_CYCLES);
    logic [AW-1:0] alarm_cnt_q;
`endif
    assign match    = bus.in == PASSWORD;
    assign fail_inc = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
    // fail_q is always 0 in OPEN, so this also covers MAX_FAILS==1 there
    assign to_alarm = bus.enter && !match && fail_inc == MAX_F && state_q != ALARM;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOCKED;
            fail_q   <= '0;
            timer_q  <= '0;
            access_q <= 1'b0;
            alarm_q  <= 1'b0;
`ifdef ALARM_AUTOCLEAR_EN
            alarm_cnt_q <= '0;
`endif
        end else if (to_alarm) begin
            state_q  <= ALARM;
            fail_q   <= fail_inc;
            timer_q  <= '0;
            access_q <= 1'b0;
            alarm_q  <= 1'b1;
`ifdef ALARM_AUTOCLEAR_EN
            alarm_cnt_q <= ALARM_LOAD;
`endif
        end else begin
            case (state_q)
                LOCKED: begin
                    if (bus.enter && match) begin
                        state_q  <= OPEN;
                        fail_q   <= '0;
                        timer_q  <= OPEN_LOAD;
                        access_q <= 1'b1;
                    end else if (bus.enter) begin
                        fail_q <= fail_inc;
                    end
                end
                OPEN: begin
                    if (bus.enter && match) begin
                        timer_q <= OPEN_LOAD;
                    end else if (bus.enter || timer_q == TW'(1)) begin
                        state_q  <= LOCKED;
                        fail_q   <= bus.enter ? 4'd1 : fail_q;
                        timer_q  <= '0;
                        access_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                ALARM: begin
`ifdef ALARM_AUTOCLEAR_EN
                    if (alarm_cnt_q == AW'(1)) begin
                        state_q     <= LOCKED;
                        fail_q      <= '0;
                        alarm_q     <= 1'b0;
                        alarm_cnt_q <= '0;
                    end else begin
                        alarm_cnt_q <= alarm_cnt_q - AW'(1);
                    end
`else
                    state_q <= ALARM;
`endif
                end
                default: begin
                    state_q  <= LOCKED;
                    access_q <= 1'b0;
                    alarm_q  <= 1'b0;
                end
            endcase
        end
    end
    assign bus.access = access_q;
    assign bus.alarm  = alarm_q;
endmodule

// File: tb/tb_password_lock.sv
// tb_password_lock: directed steps with a per-cycle scoreboard of expected
// access/alarm values.
module tb_password_lock;
    localparam logic [31:0] GOOD = 32'h12345678;
    typedef struct {
        logic  acc;
        logic  alm;
        string tag;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    exp_t sb[$];
    password_lock_if #(.WIDTH(32)) bus ();
    password_lock dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic step(input logic r, input logic e, input logic [31:0] code,
                        input logic ea, input logic eal, input string tag);
        exp_t x;
        reset     = r;
        bus.enter = e;
        bus.in    = code;
        sb.push_back('{ea, eal, tag});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        total++;
        assert (bus.access === x.acc)
        else begin
            bad++;
            $error("FAIL %s access got=%0b exp=%0b", x.tag, bus.access, x.acc);
        end
        total++;
        assert (bus.alarm === x.alm)
        else begin
            bad++;
            $error("FAIL %s alarm got=%0b exp=%0b", x.tag, bus.alarm, x.alm);
        end
    endtask
    task automatic idle(input int n, input logic ea, input logic eal, input string tag);
        repeat (n) step(1'b0, 1'b0, 32'h0, ea, eal, tag);
    endtask
    initial begin
        bus.enter = 1'b0;
        bus.in    = '0;
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "reset");
        // correct code: exactly 16 cycles of access
        step(1'b0, 1'b1, GOOD, 1'b1, 1'b0, "open");
        idle(15, 1'b1, 1'b0, "open_hold");
        idle(1, 1'b0, 1'b0, "open_expire");
        // three wrong entries raise alarm; correct code ignored in ALARM
        step(1'b0, 1'b1, 32'h14343542, 1'b0, 1'b0, "wrong1");
        step(1'b0, 1'b1, 32'h1242adcb, 1'b0, 1'b0, "wrong2");
        step(1'b0, 1'b1, 32'h1234abcd, 1'b0, 1'b1, "wrong3_alarm");
        step(1'b0, 1'b1, GOOD, 1'b0, 1'b1, "alarm_ignores_good");
`ifdef ALARM_AUTOCLEAR_EN
        idle(62, 1'b0, 1'b1, "alarm_hold");
        idle(1, 1'b0, 1'b0, "alarm_autoclear");
        step(1'b0, 1'b1, GOOD, 1'b1, 1'b0, "open_after_clear");
`else
        idle(200, 1'b0, 1'b1, "alarm_sticky");
`endif
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "reset_from_alarm");
        // correct entry clears fail count
        step(1'b0, 1'b1, 32'h12342378, 1'b0, 1'b0, "pre_wrong1");
        step(1'b0, 1'b1, 32'h1234abcd, 1'b0, 1'b0, "pre_wrong2");
        step(1'b0, 1'b1, GOOD, 1'b1, 1'b0, "clear_open");
        idle(15, 1'b1, 1'b0, "clear_hold");
        idle(1, 1'b0, 1'b0, "clear_expire");
        step(1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, "post_wrong1");
        idle(3, 1'b0, 1'b0, "idle_keeps_count");
        step(1'b0, 1'b1, 32'h00000002, 1'b0, 1'b0, "post_wrong2");
        step(1'b0, 1'b1, 32'h00000003, 1'b0, 1'b1, "post_wrong3");
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "reset2");
        // wrong entry during OPEN locks at once and counts as first failure
        step(1'b0, 1'b1, GOOD, 1'b1, 1'b0, "open2");
        idle(2, 1'b1, 1'b0, "open2_hold");
        step(1'b0, 1'b1, 32'h12acfe38, 1'b0, 1'b0, "open_wrong");
        step(1'b0, 1'b1, 32'h12acfe39, 1'b0, 1'b0, "open_wrong_f2");
        step(1'b0, 1'b1, 32'h12acfe3a, 1'b0, 1'b1, "open_wrong_f3");
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "reset3");
        // re-entry at cycle 10 restarts the 16-cycle window
        step(1'b0, 1'b1, GOOD, 1'b1, 1'b0, "reopen");
        idle(8, 1'b1, 1'b0, "reopen_hold");
        step(1'b0, 1'b1, GOOD, 1'b1, 1'b0, "reentry");
        idle(15, 1'b1, 1'b0, "reentry_hold");
        idle(1, 1'b0, 1'b0, "reentry_expire");
        // entry on the expiry cycle wins over expiry
        step(1'b0, 1'b1, GOOD, 1'b1, 1'b0, "exp_open");
        idle(15, 1'b1, 1'b0, "exp_hold");
        step(1'b0, 1'b1, GOOD, 1'b1, 1'b0, "exp_reentry");
        idle(15, 1'b1, 1'b0, "exp_reentry_hold");
        step(1'b0, 1'b1, 32'hdeadbeef, 1'b0, 1'b0, "exp_wrong");
        step(1'b0, 1'b1, 32'hdeadbeee, 1'b0, 1'b0, "exp_wrong_f2");
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "reset4");
        // reset beats a simultaneous correct entry and clears mid-OPEN
        step(1'b1, 1'b1, GOOD, 1'b0, 1'b0, "reset_with_enter");
        step(1'b0, 1'b0, GOOD, 1'b0, 1'b0, "no_enter_good_code");
        idle(2, 1'b0, 1'b0, "no_enter_idle");
        step(1'b0, 1'b1, GOOD, 1'b1, 1'b0, "open3");
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "reset_mid_open");
        // enter held high counts one attempt per cycle
        step(1'b0, 1'b1, 32'hffffffff, 1'b0, 1'b0, "held1");
        step(1'b0, 1'b1, 32'hffffffff, 1'b0, 1'b0, "held2");
        step(1'b0, 1'b1, 32'hffffffff, 1'b0, 1'b1, "held3");
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "reset5");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
